// File: rtl/pc_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit_if
// Brief    : Instruction-memory and decode-stage handshake bundle for the
//            program counter / fetch sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface pc_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] insn;
   logic        insn_valid;
   logic        insn_ready;
   logic [31:0] pc_out;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata,
      output insn,
      output insn_valid,
      input  insn_ready,
      output pc_out
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata,
      input  insn,
      input  insn_valid,
      output insn_ready,
      input  pc_out
   );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_fetch_unit
// Brief    : Program counter and REQ/VALID/ERROR fetch sequencer with fetch
//            timeout. Optional PC_MISALIGN_CHECK_EN adds misalign_err.
// Revision : 1.0  initial release
// ============================================================================
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          WAIT_LIMIT = 16
) (
   input  wire logic        clk,
   input  wire logic        reset,
   input  wire logic        pc_alu_sel,
   input  wire logic        jump,
   input  wire logic        jalr_sel,
   input  wire logic [31:0] imm,
   input  wire logic [31:0] rs1,
   pc_fetch_unit_if.master  bus,
   output      logic        fetch_err
`ifdef PC_MISALIGN_CHECK_EN
   ,
   output      logic        misalign_err
`endif
);

   localparam logic [31:0] c_nop       = 32'h0000_0013;
   localparam logic [7:0]  c_wait_last = 8'(WAIT_LIMIT - 1);

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_VALID = 2'd1,
      S_ERROR = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] r_insn;
   logic [31:0] w_insn_nxt;
   logic [7:0]  r_wait_cnt;
   logic [7:0]  w_wait_cnt_nxt;
   logic        r_fetch_err;
   logic        w_fetch_err_nxt;
   logic        r_req_mask;
   logic        w_req;
   logic [31:0] w_jalr_sum;
   logic [31:0] w_next_pc;
`ifdef PC_MISALIGN_CHECK_EN
   logic        r_misalign;
   logic        w_misalign_nxt;
`endif

   // The first cycle after reset never requests, so a stale ack is dropped.
   assign w_req = (r_state == S_REQ) && !r_req_mask;

   always_comb begin
      w_jalr_sum = rs1 + imm;
      if (jalr_sel) begin
         w_next_pc = {w_jalr_sum[31:1], 1'b0};
      end else if (jump || pc_alu_sel) begin
         w_next_pc = r_pc + imm;
      end else begin
         w_next_pc = r_pc + 32'd4;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_insn_nxt      = r_insn;
      w_wait_cnt_nxt  = r_wait_cnt;
      w_fetch_err_nxt = r_fetch_err;
`ifdef PC_MISALIGN_CHECK_EN
      w_misalign_nxt  = r_misalign;
`endif
      case (r_state)
         S_REQ: begin
            if (w_req) begin
               if (bus.imem_ack) begin
                  w_insn_nxt     = bus.imem_rdata;
                  w_wait_cnt_nxt = '0;
                  w_state_nxt    = S_VALID;
               end else if (r_wait_cnt == c_wait_last) begin
                  w_fetch_err_nxt = 1'b1;
                  w_state_nxt     = S_ERROR;
               end else begin
                  w_wait_cnt_nxt = r_wait_cnt + 8'd1;
               end
            end
         end
         S_VALID: begin
            if (bus.insn_ready) begin
`ifdef PC_MISALIGN_CHECK_EN
               if (w_next_pc[1:0] != 2'b00) begin
                  w_misalign_nxt = 1'b1;
                  w_state_nxt    = S_ERROR;
               end else begin
                  w_pc_nxt    = w_next_pc;
                  w_state_nxt = S_REQ;
               end
`else
               w_pc_nxt    = w_next_pc;
               w_state_nxt = S_REQ;
`endif
            end
         end
         S_ERROR: begin
            w_state_nxt = S_ERROR;
         end
         default: begin
            w_state_nxt = S_ERROR;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_REQ;
         r_pc        <= RESET_PC;
         r_insn      <= c_nop;
         r_wait_cnt  <= '0;
         r_fetch_err <= 1'b0;
         r_req_mask  <= 1'b1;
`ifdef PC_MISALIGN_CHECK_EN
         r_misalign  <= 1'b0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_insn      <= w_insn_nxt;
         r_wait_cnt  <= w_wait_cnt_nxt;
         r_fetch_err <= w_fetch_err_nxt;
         r_req_mask  <= 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
         r_misalign  <= w_misalign_nxt;
`endif
      end
   end

   assign bus.imem_req   = w_req;
   assign bus.imem_addr  = r_pc;
   assign bus.insn       = r_insn;
   assign bus.insn_valid = (r_state == S_VALID);
   assign bus.pc_out     = r_pc;
   assign fetch_err      = r_fetch_err;
`ifdef PC_MISALIGN_CHECK_EN
   assign misalign_err   = r_misalign;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_fetch_unit
// Brief    : Directed plus randomized bench for pc_fetch_unit against a
//            behavioural fetch model (honours PC_MISALIGN_CHECK_EN).
// Revision : 1.0  initial release
// ============================================================================
module tb_pc_fetch_unit;

   localparam logic [31:0] RESET_PC   = 32'h0000_0100;
   localparam int          WAIT_LIMIT = 4;
   localparam logic [31:0] c_nop      = 32'h0000_0013;
   localparam int          c_fetch    = 0;
   localparam int          c_hold     = 1;
   localparam int          c_dead     = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        pc_alu_sel;
   logic        jump;
   logic        jalr_sel;
   logic [31:0] imm;
   logic [31:0] rs1;
   logic        fetch_err;
`ifdef PC_MISALIGN_CHECK_EN
   logic        misalign_err;
`endif

   pc_fetch_unit_if bus ();

   pc_fetch_unit #(
      .RESET_PC   (RESET_PC),
      .WAIT_LIMIT (WAIT_LIMIT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pc_alu_sel (pc_alu_sel),
      .jump       (jump),
      .jalr_sel   (jalr_sel),
      .imm        (imm),
      .rs1        (rs1),
      .bus        (bus.master),
      .fetch_err  (fetch_err)
`ifdef PC_MISALIGN_CHECK_EN
      ,
      .misalign_err (misalign_err)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: where the fetcher is in its life, not how it is built.
   logic [31:0] m_pc;
   logic [31:0] m_insn;
   int          m_phase;
   int          m_unanswered;
   bit          m_fresh;
   bit          m_err;
   bit          m_mis;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic [31:0] branch_target(input logic [31:0] pc);
      logic [31:0] s;
      if (jalr_sel) begin
         s = rs1 + imm;
         return s - {31'd0, s[0]};
      end
      if (jump || pc_alu_sel) return pc + imm;
      return pc + 32'd4;
   endfunction

   task automatic model_edge();
      logic [31:0] tgt;
      if (reset) begin
         m_pc = RESET_PC; m_insn = c_nop; m_phase = c_fetch;
         m_unanswered = 0; m_fresh = 1; m_err = 0; m_mis = 0;
         return;
      end
      if (m_phase == c_fetch) begin
         if (m_fresh) begin
            m_fresh = 0;
         end else if (bus.imem_ack) begin
            m_insn = bus.imem_rdata; m_phase = c_hold; m_unanswered = 0;
         end else begin
            m_unanswered++;
            if (m_unanswered >= WAIT_LIMIT) begin
               m_err = 1; m_phase = c_dead;
            end
         end
      end else if (m_phase == c_hold && bus.insn_ready) begin
         tgt = branch_target(m_pc);
`ifdef PC_MISALIGN_CHECK_EN
         if (tgt % 4 != 0) begin
            m_mis = 1; m_phase = c_dead;
         end else begin
            m_pc = tgt; m_phase = c_fetch;
         end
`else
         m_pc = tgt; m_phase = c_fetch;
`endif
      end
   endtask

   task automatic compare_model();
      bit exp_req;
      exp_req = (m_phase == c_fetch) && !m_fresh;
      check("imem_req", bus.imem_req, exp_req);
      check("insn_valid", bus.insn_valid, m_phase == c_hold);
      check("fetch_err", fetch_err, m_err);
      if (exp_req) check("imem_addr", bus.imem_addr, m_pc);
      if (m_phase == c_hold) begin
         check("insn", bus.insn, m_insn);
         check("pc_out", bus.pc_out, m_pc);
      end
`ifdef PC_MISALIGN_CHECK_EN
      check("misalign_err", misalign_err, m_mis);
`endif
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      compare_model();
   endtask

   task automatic clear_ctrl();
      pc_alu_sel = 0; jump = 0; jalr_sel = 0; imm = '0; rs1 = '0;
   endtask

   initial begin
      reset = 1; clear_ctrl();
      bus.imem_ack = 0; bus.imem_rdata = '0; bus.insn_ready = 1;

      // Reset and straight-line fetch
      tick(); tick();
      check("rst_req", bus.imem_req, 1'b0);
      check("rst_insn", bus.insn, c_nop);
      check("rst_valid", bus.insn_valid, 1'b0);
      check("rst_err", fetch_err, 1'b0);
      reset = 0; bus.imem_ack = 1; bus.imem_rdata = 32'hAAAA_0001;
      tick(); check("seq_a0", bus.imem_addr, 32'h100);
      tick(); check("seq_v0", bus.insn_valid, 1'b1); check("seq_i0", bus.insn, 32'hAAAA_0001);
      tick(); check("seq_a1", bus.imem_addr, 32'h104); check("seq_v1", bus.insn_valid, 1'b0);
      tick(); check("seq_v1b", bus.insn_valid, 1'b1);
      tick(); check("seq_a2", bus.imem_addr, 32'h108);

      // Branch taken / not taken from pc 0x200
      tick(); jalr_sel = 1; rs1 = 32'h200;
      tick(); check("jalr_200", bus.imem_addr, 32'h200); clear_ctrl();
      tick(); pc_alu_sel = 1; imm = 32'hFFFF_FFF0;
      tick(); check("br_taken", bus.imem_addr, 32'h1F0); clear_ctrl();
      tick(); jalr_sel = 1; rs1 = 32'h200;
      tick(); clear_ctrl();
      tick(); imm = 32'hFFFF_FFF0;
      tick(); check("br_not_taken", bus.imem_addr, 32'h204); clear_ctrl();

      // JALR priority and bit0 clearing
      tick(); jalr_sel = 1; jump = 1; pc_alu_sel = 1; rs1 = 32'h1001; imm = 32'h4;
      tick(); check("jalr_prio", bus.imem_addr, 32'h1004); clear_ctrl();

      // Silent wrap-around
      tick(); jalr_sel = 1; rs1 = 32'hFFFF_FFFC;
      tick(); check("wrap_hi", bus.imem_addr, 32'hFFFF_FFFC); clear_ctrl();
      tick();
      tick(); check("wrap_lo", bus.imem_addr, 32'h0);

      // Decode stall: nothing moves while insn_ready is low
      tick(); bus.insn_ready = 0;
      for (int i = 0; i < 5; i++) begin
         bus.imem_ack = 1'(i); pc_alu_sel = ~1'(i); imm = 32'h40; bus.imem_rdata = $urandom;
         tick();
         check("stall_valid", bus.insn_valid, 1'b1);
         check("stall_req", bus.imem_req, 1'b0);
         check("stall_insn", bus.insn, 32'hAAAA_0001);
         check("stall_pc", bus.pc_out, 32'h0);
      end

      // Fetch timeout after WAIT_LIMIT unanswered request cycles
      clear_ctrl(); bus.insn_ready = 1; bus.imem_ack = 0;
      tick(); check("to_addr", bus.imem_addr, 32'h4);
      for (int i = 0; i < WAIT_LIMIT - 1; i++) begin
         tick(); check("to_wait_req", bus.imem_req, 1'b1); check("to_wait_err", fetch_err, 1'b0);
      end
      tick(); check("to_err", fetch_err, 1'b1); check("to_req", bus.imem_req, 1'b0);
      bus.imem_ack = 1;
      for (int i = 0; i < 3; i++) begin
         tick(); check("err_sticky", fetch_err, 1'b1); check("err_valid", bus.insn_valid, 1'b0);
      end
      reset = 1; tick(); reset = 0;
      check("rst2_err", fetch_err, 1'b0); check("rst2_req", bus.imem_req, 1'b0);
      tick(); check("rst2_addr", bus.imem_addr, RESET_PC);

      // Misaligned JALR target
      tick(); jalr_sel = 1; rs1 = 32'h2;
      tick(); clear_ctrl();
`ifdef PC_MISALIGN_CHECK_EN
      check("mis_flag", misalign_err, 1'b1);
      check("mis_req", bus.imem_req, 1'b0);
      check("mis_pc", bus.pc_out, RESET_PC);
`else
      check("mis_addr", bus.imem_addr, 32'h2);
`endif

      // Randomized traffic
      reset = 1;
      for (int i = 0; i < 4000; i++) begin
         tick();
         reset         = ($urandom_range(0, 149) == 0);
         bus.imem_ack  = ($urandom_range(0, 3) != 0);
         bus.imem_rdata = $urandom;
         bus.insn_ready = ($urandom_range(0, 4) < 3);
         jalr_sel      = ($urandom_range(0, 5) == 0);
         jump          = ($urandom_range(0, 5) == 0);
         pc_alu_sel    = ($urandom_range(0, 3) == 0);
         rs1           = $urandom;
         case ($urandom_range(0, 3))
            0:       imm = $urandom;
            1:       imm = 32'hFFFF_FFFC;
            2:       imm = 32'(4 * $urandom_range(0, 16));
            default: imm = 32'(-4 * int'($urandom_range(0, 16)));
         endcase
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
